// File: rtl/bsc_ompss_hs_to_stream_adapter_pkg.sv
// Shared widths, beat layout and a clog2 helper for the hs-to-stream adapter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bsc_ompss_hs_to_stream_adapter_pkg;

  localparam int DATA_W = 64;  // stream data width
  localparam int CNT_W  = 16;  // packet word counter width

  typedef logic [DATA_W-1:0] data_t;

  // One FIFO entry: tlast travels alongside its data word.
  typedef struct packed {
    logic  last;
    data_t data;
  } beat_t;

  // Ceiling log2, usable in constant expressions (port and pointer widths).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/bsc_ompss_hs_to_stream_adapter_if.sv
// Bundles the ap_hs input side and the AXI4-Stream output side of the adapter.
// Latency: n/a (wiring only).
// Backpressure: ap_ack and tready carry flow control in opposite directions.
interface bsc_ompss_hs_to_stream_adapter_if;
  import bsc_ompss_hs_to_stream_adapter_pkg::*;

  data_t in_hs;
  logic  in_hs_ap_vld;
  logic  in_hs_ap_ack;
  data_t outStream_tdata;
  logic  outStream_tlast;
  logic  outStream_tvalid;
  logic  outStream_tready;

  // Adapter view: it masters the stream and answers the accelerator handshake.
  modport master (
    input  in_hs, in_hs_ap_vld, outStream_tready,
    output in_hs_ap_ack, outStream_tdata, outStream_tlast, outStream_tvalid
  );

  // Environment view: accelerator source plus stream sink.
  modport slave (
    output in_hs, in_hs_ap_vld, outStream_tready,
    input  in_hs_ap_ack, outStream_tdata, outStream_tlast, outStream_tvalid
  );

endinterface

// File: rtl/bsc_ompss_sync_fifo.sv
// Single-clock FIFO with registered storage, power-of-two depth.
// Latency: a word pushed at edge N is at the head after edge N.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module bsc_ompss_sync_fifo
  import bsc_ompss_hs_to_stream_adapter_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointers carry one extra MSB so that full and empty both fall out of
  // the pointer difference without an ambiguous wrap case.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status flags, guarded handshakes and next pointer values.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset discards any buffered contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bsc_ompss_hs_to_stream_adapter.sv
// Turns an HLS ap_hs output into a 64-bit AXI4-Stream with TLAST every PKT_LEN words.
// Latency: one cycle from accepted word to tvalid/tdata.
// Backpressure: ap_ack drops while the FIFO is full; stream head holds until tready.
module bsc_ompss_hs_to_stream_adapter
  import bsc_ompss_hs_to_stream_adapter_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  bsc_ompss_hs_to_stream_adapter_if.master  hs,
  output logic [clog2(DEPTH):0]             occupancy
);

  logic             full, empty;
  logic             accept, pop, tlast_flag;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  beat_t            push_beat, head_beat;

  // Ack is purely combinational so the accelerator sees it in the same cycle;
  // it is held low during reset so no word slips in while state is cleared.
  assign hs.in_hs_ap_ack = hs.in_hs_ap_vld && !full && !areset;
  assign accept          = hs.in_hs_ap_vld && hs.in_hs_ap_ack;

  // Word counter: the PKT_LEN-th accepted word closes the packet.
  always_comb begin
    tlast_flag = (cnt_q == CNT_W'(PKT_LEN - 1));
    cnt_d      = cnt_q;
    if (accept) cnt_d = tlast_flag ? '0 : cnt_q + 1'b1;
    push_beat.last = tlast_flag;
    push_beat.data = hs.in_hs;
  end

  // Counter register; reset drops any partial packet.
  always_ff @(posedge aclk) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  bsc_ompss_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (accept),
    .push_dat (push_beat),
    .pop      (pop),
    .pop_dat  (head_beat),
    .full     (full),
    .empty    (empty),
    .count    (occupancy)
  );

  // Stream side comes straight from the FIFO head; nothing from in_hs reaches it.
  assign hs.outStream_tvalid = !empty;
  assign hs.outStream_tdata  = head_beat.data;
  assign hs.outStream_tlast  = head_beat.last;
  assign pop                 = hs.outStream_tvalid && hs.outStream_tready;

endmodule

// File: tb/tb_bsc_ompss_hs_to_stream_adapter.sv
// Directed and scoreboard checks of the adapter at PKT_LEN 1, 3 and 4 (DEPTH 4).
// Latency: inputs change on the falling edge, outputs are sampled 1 time unit later.
// Backpressure: tready is driven directly, randomly in the final phase.
module tb_bsc_ompss_hs_to_stream_adapter;
  import bsc_ompss_hs_to_stream_adapter_pkg::*;

  logic        aclk;
  logic        areset;
  logic [63:0] in_hs;
  logic        vld;
  logic        tready;
  logic [2:0]  occ1, occ3, occ4;

  int n_chk  = 0;
  int n_pass = 0;

  bsc_ompss_hs_to_stream_adapter_if hs1 ();
  bsc_ompss_hs_to_stream_adapter_if hs3 ();
  bsc_ompss_hs_to_stream_adapter_if hs4 ();

  // All three instances see identical stimulus; only tlast placement differs.
  assign hs1.in_hs = in_hs;  assign hs1.in_hs_ap_vld = vld;  assign hs1.outStream_tready = tready;
  assign hs3.in_hs = in_hs;  assign hs3.in_hs_ap_vld = vld;  assign hs3.outStream_tready = tready;
  assign hs4.in_hs = in_hs;  assign hs4.in_hs_ap_vld = vld;  assign hs4.outStream_tready = tready;

  bsc_ompss_hs_to_stream_adapter #(.DEPTH(4), .PKT_LEN(1)) u1 (
    .aclk(aclk), .areset(areset), .hs(hs1.master), .occupancy(occ1));
  bsc_ompss_hs_to_stream_adapter #(.DEPTH(4), .PKT_LEN(3)) u3 (
    .aclk(aclk), .areset(areset), .hs(hs3.master), .occupancy(occ3));
  bsc_ompss_hs_to_stream_adapter #(.DEPTH(4), .PKT_LEN(4)) u4 (
    .aclk(aclk), .areset(areset), .hs(hs4.master), .occupancy(occ4));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one full clock, ending on the falling edge.
  task automatic cyc();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    vld    = 1'b0;
    tready = 1'b0;
    cyc();
    areset = 1'b0;
  endtask

  // Scoreboard state for the random phase.
  data_t q[$];
  logic  q3[$];
  logic  q4[$];
  int    c3, c4;
  logic  exp_ack, held, held_last;
  logic [63:0] held_dat;

  initial begin
    areset = 1'b1;
    vld    = 1'b1;
    tready = 1'b1;
    in_hs  = 64'h0;
    @(negedge aclk);

    // 1. Reset, then a single word with minimum latency.
    #1;
    chk("rst_ack0", hs4.in_hs_ap_ack, 1'b0);
    chk("rst_vld0", hs4.outStream_tvalid, 1'b0);
    chk("rst_occ0", occ4, 0);
    cyc();
    #1;
    chk("rst_ack1", hs4.in_hs_ap_ack, 1'b0);
    chk("rst_vld1", hs4.outStream_tvalid, 1'b0);
    cyc();
    areset = 1'b0;
    in_hs  = 64'h1;
    vld    = 1'b1;
    #1;
    chk("t1_ack", hs4.in_hs_ap_ack, 1'b1);
    chk("t1_vld_same_cycle", hs4.outStream_tvalid, 1'b0);
    cyc();
    vld = 1'b0;
    #1;
    chk("t1_vld", hs4.outStream_tvalid, 1'b1);
    chk("t1_dat", hs4.outStream_tdata, 64'h1);
    chk("t1_last_p1", hs1.outStream_tlast, 1'b1);
    chk("t1_last_p4", hs4.outStream_tlast, 1'b0);
    cyc();
    #1;
    chk("t1_drained", hs4.outStream_tvalid, 1'b0);

    // 2. Back-to-back stream, PKT_LEN=4 boundaries on 0x13 and 0x17.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vld   = (i < 8);
      in_hs = 64'h10 + 64'(i);
      #1;
      if (i < 8) chk("t2_ack", hs4.in_hs_ap_ack, 1'b1);
      if (i > 0) begin
        chk("t2_vld", hs4.outStream_tvalid, 1'b1);
        chk("t2_dat", hs4.outStream_tdata, 64'h10 + 64'(i - 1));
        chk("t2_last", hs4.outStream_tlast, ((i - 1) % 4) == 3);
      end
      cyc();
    end
    #1;
    chk("t2_empty", hs4.outStream_tvalid, 1'b0);

    // 3. Backpressure: only DEPTH words accepted, head held, then ordered drain.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld   = 1'b1;
      in_hs = 64'h20 + 64'(i);
      #1;
      chk("t3_ack", hs4.in_hs_ap_ack, i < 4);
      if (i > 0) chk("t3_head_hold", hs4.outStream_tdata, 64'h20);
      cyc();
    end
    vld = 1'b0;
    #1;
    chk("t3_occ_full", occ4, 4);
    chk("t3_vld", hs4.outStream_tvalid, 1'b1);
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_drain", hs4.outStream_tdata, 64'h20 + 64'(k));
      cyc();
    end
    #1;
    chk("t3_occ_empty", occ4, 0);
    chk("t3_vld_end", hs4.outStream_tvalid, 1'b0);

    // 4. Full with simultaneous pop: no push that cycle, push next cycle.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld   = 1'b1;
      in_hs = 64'h30 + 64'(i);
      cyc();
    end
    in_hs  = 64'h34;
    tready = 1'b1;
    #1;
    chk("t4_ack_full", hs4.in_hs_ap_ack, 1'b0);
    chk("t4_head", hs4.outStream_tdata, 64'h30);
    cyc();
    tready = 1'b0;
    #1;
    chk("t4_occ_after_pop", occ4, 3);
    chk("t4_ack_next", hs4.in_hs_ap_ack, 1'b1);
    cyc();
    vld    = 1'b0;
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_drain", hs4.outStream_tdata, 64'h31 + 64'(k));
      cyc();
    end
    #1;
    chk("t4_empty", hs4.outStream_tvalid, 1'b0);

    // 5. Reset mid-packet at PKT_LEN=3: stale words and partial count vanish.
    do_reset();
    tready = 1'b0;
    vld    = 1'b1;
    in_hs  = 64'h50;
    cyc();
    in_hs = 64'h51;
    cyc();
    areset = 1'b1;
    #1;
    chk("t5_ack_in_rst", hs3.in_hs_ap_ack, 1'b0);
    cyc();
    areset = 1'b0;
    vld    = 1'b0;
    #1;
    chk("t5_vld_after_rst", hs3.outStream_tvalid, 1'b0);
    chk("t5_occ_after_rst", occ3, 0);
    for (int i = 0; i < 3; i++) begin
      vld   = 1'b1;
      in_hs = 64'hA + 64'(i);
      cyc();
    end
    vld    = 1'b0;
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_dat", hs3.outStream_tdata, 64'hA + 64'(k));
      chk("t5_last", hs3.outStream_tlast, k == 2);
      cyc();
    end
    #1;
    chk("t5_empty", hs3.outStream_tvalid, 1'b0);

    // 6. Random handshakes against a queue model.
    do_reset();
    c3   = 0;
    c4   = 0;
    held = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      vld    = ($urandom_range(0, 3) != 0);
      in_hs  = {$urandom, $urandom};
      tready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ack = vld && (q.size() < 4);
      chk("rnd_ack", hs4.in_hs_ap_ack, exp_ack);
      chk("rnd_occ4", occ4, q.size());
      chk("rnd_occ1", occ1, q.size());
      chk("rnd_occ3", occ3, q.size());
      chk("rnd_vld", hs4.outStream_tvalid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_dat", hs4.outStream_tdata, q[0]);
        chk("rnd_last1", hs1.outStream_tlast, 1'b1);
        chk("rnd_last3", hs3.outStream_tlast, q3[0]);
        chk("rnd_last4", hs4.outStream_tlast, q4[0]);
      end
      if (held) begin
        chk("rnd_hold_dat", hs4.outStream_tdata, held_dat);
        chk("rnd_hold_last", hs4.outStream_tlast, held_last);
      end
      held      = hs4.outStream_tvalid && !tready;
      held_dat  = hs4.outStream_tdata;
      held_last = hs4.outStream_tlast;
      if (q.size() != 0 && tready) begin
        void'(q.pop_front());
        void'(q3.pop_front());
        void'(q4.pop_front());
      end
      if (exp_ack) begin
        q.push_back(in_hs);
        q3.push_back(c3 == 2);
        q4.push_back(c4 == 3);
        c3 = (c3 == 2) ? 0 : c3 + 1;
        c4 = (c4 == 3) ? 0 : c4 + 1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
